// File: rtl/seq_medicao_uc_pkg.sv
// seq_medicao_uc_pkg: state codes (also the db_estado values) and width helper
// shared by the measure/transmit/receive control unit and its counters.
`default_nettype none

package seq_medicao_uc_pkg;

    localparam logic [3:0] ST_INICIAL     = 4'd0;
    localparam logic [3:0] ST_MEDIR       = 4'd1;
    localparam logic [3:0] ST_ESP_SEG     = 4'd2;
    localparam logic [3:0] ST_ENVIA       = 4'd3;
    localparam logic [3:0] ST_PROX_ENVIO  = 4'd4;
    localparam logic [3:0] ST_PROX_SENSOR = 4'd5;
    localparam logic [3:0] ST_ESP_RECEP   = 4'd6;
    localparam logic [3:0] ST_PROX_RECEP  = 4'd7;
    localparam logic [3:0] ST_FINAL       = 4'd8;
    localparam logic [3:0] ST_ERRO        = 4'd9;

    // Index width for a modulus n; a single-value index still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_medicao_uc_contador_m.sv
// contador_m: mod-M counter with synchronous clear and enable; fim_o flags
// the last value so the sequencer can decide to leave the loop.
`default_nettype none

module contador_m
    import seq_medicao_uc_pkg::*;
#(
    parameter  int M = 4,
    localparam int W = clog2_min1(M)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic         fim_o
);

    localparam logic [W-1:0] MAX = W'(M - 1);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = (q_q == MAX) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign fim_o = (q_q == MAX);

endmodule

`default_nettype wire

// File: rtl/seq_medicao_uc.sv
// seq_medicao_uc: Moore sequencer for one measure / transmit / receive round,
// with handshake timeout (sticky error flag) and auto-repeat mode.
`default_nettype none

module seq_medicao_uc
    import seq_medicao_uc_pkg::*;
#(
    parameter  int N_SENSORES = 3,
    parameter  int N_BYTES    = 4,
    parameter  int N_RECEP    = 3,
    parameter  int TIMEOUT    = 50000,
    localparam int SW         = clog2_min1(N_SENSORES),
    localparam int BW         = clog2_min1(N_BYTES),
    localparam int RW         = clog2_min1(N_RECEP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          jogar_i,
    input  logic          modo_continuo_i,
    input  logic          pronto_seg_i,
    input  logic          pronto_serial_i,
    input  logic          pronto_recepcao_i,
    output logic          zera_sensor_o,
    output logic          zera_serial_o,
    output logic          zera_seg_o,
    output logic          medir_o,
    output logic          cont_seg_o,
    output logic          partida_tx_o,
    output logic [SW-1:0] sel_sensor_o,
    output logic [BW-1:0] sel_byte_o,
    output logic [RW-1:0] idx_recepcao_o,
    output logic          cont_recepcao_o,
    output logic          pronto_o,
    output logic          erro_timeout_o,
    output logic [3:0]    db_estado_o
);

    localparam int             TW        = clog2_min1(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LIM = TW'(TIMEOUT - 1);

    logic [3:0]    estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          erro_q, erro_d;
    logic          w_fim_byte, w_fim_sensor, w_fim_recep;
    logic          w_limpa, w_conta, w_timeout;

    assign w_limpa   = (estado_q == ST_INICIAL) || (estado_q == ST_ERRO);
    assign w_conta   = (estado_q == ST_ENVIA) || (estado_q == ST_ESP_RECEP);
    assign w_timeout = (timer_q == TIMER_LIM);

    contador_m #(.M(N_BYTES)) u_cnt_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_limpa),
        .en_i  (estado_q == ST_PROX_ENVIO),
        .q_o   (sel_byte_o),
        .fim_o (w_fim_byte)
    );

    contador_m #(.M(N_SENSORES)) u_cnt_sensor (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_limpa),
        .en_i  (estado_q == ST_PROX_SENSOR),
        .q_o   (sel_sensor_o),
        .fim_o (w_fim_sensor)
    );

    contador_m #(.M(N_RECEP)) u_cnt_recep (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_limpa),
        .en_i  (estado_q == ST_PROX_RECEP),
        .q_o   (idx_recepcao_o),
        .fim_o (w_fim_recep)
    );

    // A handshake arriving in the last allowed cycle takes priority over the timeout.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL:     if (jogar_i) estado_d = ST_MEDIR;
            ST_MEDIR:       estado_d = ST_ESP_SEG;
            ST_ESP_SEG:     if (pronto_seg_i) estado_d = ST_ENVIA;
            ST_ENVIA: begin
                if (pronto_serial_i)  estado_d = ST_PROX_ENVIO;
                else if (w_timeout)   estado_d = ST_ERRO;
            end
            ST_PROX_ENVIO:  estado_d = w_fim_byte ? ST_PROX_SENSOR : ST_ENVIA;
            ST_PROX_SENSOR: estado_d = w_fim_sensor ? ST_ESP_RECEP : ST_ENVIA;
            ST_ESP_RECEP: begin
                if (pronto_recepcao_i) estado_d = ST_PROX_RECEP;
                else if (w_timeout)    estado_d = ST_ERRO;
            end
            ST_PROX_RECEP:  estado_d = w_fim_recep ? ST_FINAL : ST_ESP_RECEP;
            ST_FINAL:       estado_d = modo_continuo_i ? ST_MEDIR : ST_INICIAL;
            default:        estado_d = ST_INICIAL;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (w_conta && (estado_d == estado_q)) begin
            timer_d = w_timeout ? timer_q : timer_q + TW'(1);
        end
    end

    always_comb begin
        erro_d = erro_q;
        if ((estado_q == ST_INICIAL) && jogar_i) erro_d = 1'b0;
        if ((estado_d == ST_ERRO) && (estado_q != ST_ERRO)) erro_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ST_INICIAL;
            timer_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            erro_q   <= erro_d;
        end
    end

    assign zera_sensor_o   = (estado_q == ST_INICIAL);
    assign zera_serial_o   = (estado_q == ST_INICIAL);
    assign zera_seg_o      = (estado_q == ST_INICIAL);
    assign medir_o         = (estado_q == ST_MEDIR);
    assign cont_seg_o      = (estado_q == ST_ESP_SEG);
    assign partida_tx_o    = (estado_q == ST_ENVIA);
    assign cont_recepcao_o = (estado_q == ST_PROX_RECEP);
    assign pronto_o        = (estado_q == ST_FINAL);
    assign erro_timeout_o  = erro_q;
    assign db_estado_o     = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_medicao_uc.sv
// tb_seq_medicao_uc: walks whole rounds with random handshake delays and noise
// on ignored inputs, comparing every cycle against the round's expected trace.
`default_nettype none

module tb_seq_medicao_uc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, jogar, modo, pseg, pser, prec, usa_b;
    int   total = 0;
    int   bad   = 0;
    bit   exp_err;

    logic       a_zs, a_zr, a_zg, a_med, a_cs, a_ptx, a_crec, a_pr, a_err;
    logic [1:0] a_ss, a_sb, a_idx;
    logic [3:0] a_db;
    logic       b_zs, b_zr, b_zg, b_med, b_cs, b_ptx, b_crec, b_pr, b_err;
    logic [0:0] b_ss, b_sb, b_idx;
    logic [3:0] b_db;
    logic [18:0] obs;

    seq_medicao_uc #(.N_SENSORES(3), .N_BYTES(4), .N_RECEP(3), .TIMEOUT(8)) u_a (
        .clk(clk), .rst_n(rst_n), .jogar_i(jogar & ~usa_b), .modo_continuo_i(modo),
        .pronto_seg_i(pseg), .pronto_serial_i(pser), .pronto_recepcao_i(prec),
        .zera_sensor_o(a_zs), .zera_serial_o(a_zr), .zera_seg_o(a_zg),
        .medir_o(a_med), .cont_seg_o(a_cs), .partida_tx_o(a_ptx),
        .sel_sensor_o(a_ss), .sel_byte_o(a_sb), .idx_recepcao_o(a_idx),
        .cont_recepcao_o(a_crec), .pronto_o(a_pr), .erro_timeout_o(a_err),
        .db_estado_o(a_db)
    );

    seq_medicao_uc #(.N_SENSORES(1), .N_BYTES(1), .N_RECEP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .jogar_i(jogar & usa_b), .modo_continuo_i(modo),
        .pronto_seg_i(pseg), .pronto_serial_i(pser), .pronto_recepcao_i(prec),
        .zera_sensor_o(b_zs), .zera_serial_o(b_zr), .zera_seg_o(b_zg),
        .medir_o(b_med), .cont_seg_o(b_cs), .partida_tx_o(b_ptx),
        .sel_sensor_o(b_ss), .sel_byte_o(b_sb), .idx_recepcao_o(b_idx),
        .cont_recepcao_o(b_crec), .pronto_o(b_pr), .erro_timeout_o(b_err),
        .db_estado_o(b_db)
    );

    always_comb begin
        if (usa_b)
            obs = {b_db, b_zs, b_zr, b_zg, b_med, b_cs, b_ptx, b_crec, b_pr, b_err,
                   1'b0, b_ss, 1'b0, b_sb, 1'b0, b_idx};
        else
            obs = {a_db, a_zs, a_zr, a_zg, a_med, a_cs, a_ptx, a_crec, a_pr, a_err,
                   a_ss, a_sb, a_idx};
    end

    // Expected output vector for a state code and the indices of the round position.
    function automatic logic [18:0] modelo(input int code, input int ss, input int sb,
                                           input int idx, input bit err);
        logic [3:0] c;
        logic [1:0] s2, b2, i2;
        c  = 4'(code);
        s2 = 2'(ss);
        b2 = 2'(sb);
        i2 = 2'(idx);
        return {c, (code == 0) ? 3'b111 : 3'b000, code == 1, code == 2, code == 3,
                code == 7, code == 8, err, s2, b2, i2};
    endfunction

    task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic espera(input string tag, input int code, input int ss, input int sb,
                          input int idx);
        confere(tag, 32'(obs), 32'(modelo(code, ss, sb, idx, exp_err)));
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic limpa();
        jogar = 1'b0; modo = 1'b0; pseg = 1'b0; pser = 1'b0; prec = 1'b0;
    endtask

    // Random activity only on inputs the current state must ignore.
    task automatic ruido(input bit en_seg, input bit en_ser, input bit en_rec);
        limpa();
        jogar = 1'($urandom);
        modo  = 1'($urandom);
        if (en_seg) pseg = 1'($urandom);
        if (en_ser) pser = 1'($urandom);
        if (en_rec) prec = 1'($urandom);
    endtask

    task automatic rodada(input int ns, input int nb, input int nr, input bit cont,
                          input bit novo, input int tmax, input bit borda, input int aborta_s);
        int d;
        if (novo) begin
            limpa();
            jogar = 1'b1;
            ciclo();
            exp_err = 1'b0;
        end
        limpa();
        espera("medir", 1, 0, 0, 0);
        ciclo();
        espera("esp_seg", 2, 0, 0, 0);
        d = $urandom_range(0, 3);
        repeat (d) begin
            ruido(1'b0, 1'b1, 1'b1);
            ciclo();
            espera("esp_seg_hold", 2, 0, 0, 0);
        end
        limpa();
        pseg = 1'b1;
        ciclo();
        pseg = 1'b0;
        for (int s = 0; s < ns; s++) begin
            for (int b = 0; b < nb; b++) begin
                espera("envia", 3, s, b, 0);
                d = (borda && s == 0 && b == 0) ? tmax - 1 : $urandom_range(0, tmax - 1);
                repeat (d) begin
                    ruido(1'b1, 1'b0, 1'b1);
                    ciclo();
                    espera("envia_hold", 3, s, b, 0);
                end
                limpa();
                pser = 1'b1;
                ciclo();
                pser = 1'b0;
                espera("prox_envio", 4, s, b, 0);
                ciclo();
                if (b == nb - 1) begin
                    espera("prox_sensor", 5, s, 0, 0);
                    if (s == aborta_s) begin
                        #2 rst_n = 1'b0;
                        exp_err = 1'b0;
                        #1 espera("reset_async", 0, 0, 0, 0);
                        ciclo();
                        espera("reset_hold", 0, 0, 0, 0);
                        rst_n = 1'b1;
                        return;
                    end
                    ciclo();
                end
            end
        end
        for (int r = 0; r < nr; r++) begin
            espera("esp_recep", 6, 0, 0, r);
            d = (borda && r == 0) ? tmax - 1 : $urandom_range(0, tmax - 1);
            repeat (d) begin
                ruido(1'b1, 1'b1, 1'b0);
                ciclo();
                espera("esp_recep_hold", 6, 0, 0, r);
            end
            limpa();
            prec = 1'b1;
            ciclo();
            prec = 1'b0;
            espera("prox_recep", 7, 0, 0, r);
            ciclo();
        end
        espera("final", 8, 0, 0, 0);
        limpa();
        modo = cont;
        ciclo();
        modo = 1'b0;
        if (!cont) espera("inicial_fim", 0, 0, 0, 0);
    endtask

    task automatic teste_timeout();
        limpa();
        jogar = 1'b1;
        ciclo();
        jogar = 1'b0;
        exp_err = 1'b0;
        espera("to_medir", 1, 0, 0, 0);
        ciclo();
        pseg = 1'b1;
        ciclo();
        pseg = 1'b0;
        espera("to_envia0", 3, 0, 0, 0);
        pser = 1'b1;
        ciclo();
        pser = 1'b0;
        espera("to_prox_envio", 4, 0, 0, 0);
        ciclo();
        for (int k = 0; k < 8; k++) begin
            espera("to_envia_wait", 3, 0, 1, 0);
            ciclo();
        end
        exp_err = 1'b1;
        espera("to_erro", 9, 0, 1, 0);
        ciclo();
        for (int k = 0; k < 3; k++) begin
            espera("to_inicial_sticky", 0, 0, 0, 0);
            ciclo();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        usa_b   = 1'b0;
        exp_err = 1'b0;
        limpa();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        ciclo();
        ciclo();
        espera("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        ciclo();
        jogar = 1'b0;
        espera("idle", 0, 0, 0, 0);

        rodada(3, 4, 3, 1'b0, 1'b1, 8, 1'b1, -1);
        for (int i = 0; i < 3; i++) rodada(3, 4, 3, 1'b0, 1'b1, 8, 1'b0, -1);

        teste_timeout();
        rodada(3, 4, 3, 1'b0, 1'b1, 8, 1'b0, -1);

        rodada(3, 4, 3, 1'b1, 1'b1, 8, 1'b0, -1);
        rodada(3, 4, 3, 1'b1, 1'b0, 8, 1'b0, -1);
        rodada(3, 4, 3, 1'b0, 1'b0, 8, 1'b0, -1);

        rodada(3, 4, 3, 1'b0, 1'b1, 8, 1'b0, 1);
        espera("after_abort", 0, 0, 0, 0);
        rodada(3, 4, 3, 1'b0, 1'b1, 8, 1'b0, -1);

        usa_b = 1'b1;
        #1 espera("b_idle", 0, 0, 0, 0);
        rodada(1, 1, 1, 1'b0, 1'b1, 8, 1'b1, -1);
        rodada(1, 1, 1, 1'b1, 1'b1, 8, 1'b0, -1);
        rodada(1, 1, 1, 1'b0, 1'b0, 8, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
